// File: rtl/tile_tcdm_arbiter.sv
// Tile TCDM interconnect: NumPorts requesters onto BankingFactor word-interleaved
// SRAM banks. Per-bank round-robin arbitration, single-cycle bank latency and a
// fixed one-cycle response path per port. Out-of-range requests are answered
// locally with an error response and never reach a bank.
module tile_tcdm_arbiter #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned BankingFactor = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned BankWords     = 1024,
    localparam int unsigned BeWidth       = DataWidth / 8,
    localparam int unsigned BankAddrWidth = $clog2(BankWords)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NumPorts-1:0]                          req_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]           addr_i,
    input  logic [NumPorts-1:0]                          we_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]           wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]             be_i,
    output logic [NumPorts-1:0]                          gnt_o,
    output logic [NumPorts-1:0]                          vld_o,
    output logic [NumPorts-1:0][DataWidth-1:0]           rdata_o,
    output logic [NumPorts-1:0]                          err_o,
    output logic [BankingFactor-1:0]                     bank_req_o,
    output logic [BankingFactor-1:0]                     bank_we_o,
    output logic [BankingFactor-1:0][BankAddrWidth-1:0]  bank_addr_o,
    output logic [BankingFactor-1:0][DataWidth-1:0]      bank_wdata_o,
    output logic [BankingFactor-1:0][BeWidth-1:0]        bank_be_o,
    input  logic [BankingFactor-1:0][DataWidth-1:0]      bank_rdata_i
);

    localparam int unsigned ByteOffset = $clog2(BeWidth);
    localparam int unsigned BankSelW   = $clog2(BankingFactor);
    localparam int unsigned PortIdxW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    // Total addressable bytes; one extra bit so the compare cannot wrap.
    localparam logic [AddrWidth:0] MemBytes = (AddrWidth + 1)'(BankingFactor * BankWords * BeWidth);

    // Address decode per port
    logic [NumPorts-1:0][BankSelW-1:0]      port_bank;
    logic [NumPorts-1:0][BankAddrWidth-1:0] port_row;
    logic [NumPorts-1:0]                    port_oor;
    logic [NumPorts-1:0]                    oor_gnt;

    // Per-bank one-hot grant vectors and round-robin pointers
    logic [BankingFactor-1:0][NumPorts-1:0] bank_gnt;
    logic [BankingFactor-1:0][PortIdxW-1:0] rr_q, rr_d;

    // Per-port response state
    logic [NumPorts-1:0]                vld_q, vld_d;
    logic [NumPorts-1:0]                err_q, err_d;
    logic [NumPorts-1:0]                we_q, we_d;
    logic [NumPorts-1:0][BankSelW-1:0]  bank_q, bank_d;

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        assign port_bank[gi] = addr_i[gi][ByteOffset +: BankSelW];
        assign port_row[gi]  = addr_i[gi][ByteOffset + BankSelW +: BankAddrWidth];
        assign port_oor[gi]  = {1'b0, addr_i[gi]} >= MemBytes;
        // Out-of-range requests need no bank, so they are always accepted.
        assign oor_gnt[gi]   = req_i[gi] & port_oor[gi] & ~rst_i;
        // A port targets exactly one bank, so only that bank's grant bit matters.
        assign gnt_o[gi]     = oor_gnt[gi] | bank_gnt[port_bank[gi]][gi];
        // Responses are masked while reset is held so a grant issued just
        // before reset never surfaces.
        assign vld_o[gi]     = vld_q[gi] & ~rst_i;
        assign err_o[gi]     = vld_o[gi] & err_q[gi];
        assign rdata_o[gi]   = (vld_o[gi] && !err_q[gi] && !we_q[gi]) ? bank_rdata_i[bank_q[gi]] : '0;
    end

    for (genvar gi = 0; gi < BankingFactor; gi++) begin : g_bank
        logic [NumPorts-1:0] elig;
        logic                win_vld;
        logic [PortIdxW-1:0] win_idx;

        for (genvar gj = 0; gj < NumPorts; gj++) begin : g_elig
            assign elig[gj] = req_i[gj] & ~port_oor[gj] & ~rst_i
                            & (port_bank[gj] == BankSelW'(gi));
        end

        // Round-robin search: first eligible port at or after the pointer wins.
        always_comb begin
            int unsigned         cand;
            logic [PortIdxW-1:0] cand_idx;
            win_vld  = 1'b0;
            win_idx  = '0;
            cand     = 0;
            cand_idx = '0;
            for (int unsigned k = 0; k < NumPorts; k++) begin
                cand = 32'(rr_q[gi]) + k;
                if (cand >= NumPorts) begin
                    cand = cand - NumPorts;
                end
                cand_idx = PortIdxW'(cand);
                if (!win_vld && elig[cand_idx]) begin
                    win_vld = 1'b1;
                    win_idx = cand_idx;
                end
            end
        end

        assign bank_gnt[gi]     = win_vld ? (NumPorts'(1) << win_idx) : '0;
        assign bank_req_o[gi]   = win_vld;
        assign bank_we_o[gi]    = win_vld & we_i[win_idx];
        assign bank_addr_o[gi]  = win_vld ? port_row[win_idx] : '0;
        assign bank_wdata_o[gi] = win_vld ? wdata_i[win_idx] : '0;
        assign bank_be_o[gi]    = win_vld ? be_i[win_idx] : '0;
        // Pointer moves past the winner only when this bank actually grants.
        assign rr_d[gi] = !win_vld ? rr_q[gi]
                        : (win_idx == PortIdxW'(NumPorts - 1)) ? '0
                        : win_idx + 1'b1;
    end

    // Capture what each granted request needs to form its response next cycle.
    always_comb begin
        vld_d  = gnt_o;
        err_d  = port_oor;
        we_d   = we_i;
        bank_d = port_bank;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            vld_q  <= '0;
            err_q  <= '0;
            we_q   <= '0;
            bank_q <= '0;
        end else begin
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            we_q   <= we_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: tb/tb_tile_tcdm_arbiter.sv
// Directed bench for tile_tcdm_arbiter with default parameters and a simple
// behavioural SRAM model behind each bank (one-cycle read latency).
module tb_tile_tcdm_arbiter;

    logic                  clk;
    logic                  rst;
    logic [3:0]            req, we, gnt, vld, err;
    logic [3:0][31:0]      addr, wdata, rdata;
    logic [3:0][3:0]       be;
    logic [3:0]            breq, bwe;
    logic [3:0][9:0]       baddr;
    logic [3:0][31:0]      bwdata, brdata;
    logic [3:0][3:0]       bbe;

    logic [31:0] mem [4][1024];

    int checks = 0;
    int errors = 0;

    tile_tcdm_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .addr_i       (addr),
        .we_i         (we),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .vld_o        (vld),
        .rdata_o      (rdata),
        .err_o        (err),
        .bank_req_o   (breq),
        .bank_we_o    (bwe),
        .bank_addr_o  (baddr),
        .bank_wdata_o (bwdata),
        .bank_be_o    (bbe),
        .bank_rdata_i (brdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: contents preset to 0xA0bb_rrrr while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                for (int r = 0; r < 1024; r++) begin
                    mem[b][r] <= 32'hA000_0000 | (32'(b) << 16) | 32'(r);
                end
            end
            brdata <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (breq[b]) begin
                    if (bwe[b]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (bbe[b][k]) mem[b][baddr[b]][8*k +: 8] <= bwdata[b][8*k +: 8];
                        end
                    end else begin
                        brdata[b] <= mem[b][baddr[b]];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string name);
        $display("txn t=%0t %s req=%b we=%b gnt=%b bank_req=%b vld=%b err=%b",
                 $time, name, req, we, gnt, breq, vld, err);
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] e);
        addr[p]  = a;
        we[p]    = w;
        wdata[p] = d;
        be[p]    = e;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        cyc();

        // Requests during reset must be ignored.
        req = 4'hF;
        #1;
        txn("reset_req");
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_bank_req", 64'(breq), 64'h0);
        cyc();
        rst = 1'b0;
        req = '0;
        #1;
        check("post_rst_vld", 64'(vld), 64'h0);
        check("post_rst_err", 64'(err), 64'h0);

        // Single read of 0x8 -> bank 2 row 0.
        set_port(0, 32'h0000_0008, 1'b0, 32'h0, 4'hF);
        req = 4'b0001;
        #1;
        txn("single_read");
        check("single_gnt", 64'(gnt), 64'b0001);
        check("single_bank_req", 64'(breq), 64'b0100);
        check("single_bank_addr", 64'(baddr[2]), 64'h0);
        cyc();
        req = '0;
        #1;
        check("single_vld", 64'(vld), 64'b0001);
        check("single_rdata", 64'(rdata[0]), 64'hA002_0000);

        // Four ports, four different banks: all granted together.
        set_port(0, 32'h0, 1'b0, 32'h0, 4'hF);
        set_port(1, 32'h4, 1'b0, 32'h0, 4'hF);
        set_port(2, 32'h8, 1'b0, 32'h0, 4'hF);
        set_port(3, 32'hC, 1'b0, 32'h0, 4'hF);
        req = 4'hF;
        #1;
        txn("no_conflict");
        check("nc_gnt", 64'(gnt), 64'hF);
        check("nc_bank_req", 64'(breq), 64'hF);
        cyc();
        req = '0;
        #1;
        check("nc_vld", 64'(vld), 64'hF);
        check("nc_rdata1", 64'(rdata[1]), 64'hA001_0000);
        check("nc_rdata3", 64'(rdata[3]), 64'hA003_0000);

        // Out-of-range write at exactly the first illegal byte address.
        set_port(2, 32'h0000_4000, 1'b1, 32'h1234_5678, 4'hF);
        req = 4'b0100;
        #1;
        txn("oor_write");
        check("oor_gnt", 64'(gnt), 64'b0100);
        check("oor_bank_req", 64'(breq), 64'h0);
        cyc();
        req = '0;
        #1;
        check("oor_vld", 64'(vld), 64'b0100);
        check("oor_err", 64'(err), 64'b0100);
        check("oor_rdata", 64'(rdata[2]), 64'h0);

        // Last legal word (0x3FFC) is in range: bank 3 row 1023.
        set_port(2, 32'h0000_3FFC, 1'b0, 32'h0, 4'hF);
        req = 4'b0100;
        #1;
        txn("last_word");
        check("last_bank_req", 64'(breq), 64'b1000);
        check("last_bank_addr", 64'(baddr[3]), 64'd1023);
        cyc();
        req = '0;
        #1;
        check("last_err", 64'(err), 64'h0);
        check("last_rdata", 64'(rdata[2]), 64'hA003_03FF);

        // Write then back-to-back read of 0x14 -> bank 1 row 1.
        set_port(1, 32'h0000_0014, 1'b1, 32'hDEAD_BEEF, 4'hF);
        req = 4'b0010;
        #1;
        txn("wr_0x14");
        check("wr_gnt", 64'(gnt), 64'b0010);
        check("wr_bank_we", 64'(bwe), 64'b0010);
        check("wr_bank_addr", 64'(baddr[1]), 64'h1);
        check("wr_bank_wdata", 64'(bwdata[1]), 64'hDEAD_BEEF);
        cyc();
        set_port(1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
        #1;
        txn("rd_0x14");
        check("wr_vld", 64'(vld), 64'b0010);
        check("wr_rdata", 64'(rdata[1]), 64'h0);
        check("rd_gnt", 64'(gnt), 64'b0010);
        cyc();
        req = '0;
        #1;
        check("rd_vld", 64'(vld), 64'b0010);
        check("rd_rdata", 64'(rdata[1]), 64'hDEAD_BEEF);

        // Reset right after a grant: the response must never appear.
        set_port(3, 32'h0000_0004, 1'b0, 32'h0, 4'hF);
        req = 4'b1000;
        #1;
        txn("pre_reset");
        check("pre_rst_gnt", 64'(gnt), 64'b1000);
        cyc();
        rst = 1'b1;
        req = '0;
        #1;
        check("mid_rst_vld", 64'(vld), 64'h0);
        check("mid_rst_rdata", 64'(rdata[3]), 64'h0);
        cyc();
        rst = 1'b0;
        #1;
        check("after_rst_vld", 64'(vld), 64'h0);

        // All four ports hammer bank 1 (rows 0..3): grants rotate from port 0.
        set_port(0, 32'h0000_0004, 1'b0, 32'h0, 4'hF);
        set_port(1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
        set_port(2, 32'h0000_0024, 1'b0, 32'h0, 4'hF);
        set_port(3, 32'h0000_0034, 1'b0, 32'h0, 4'hF);
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            txn("conflict");
            check("cf_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
            check("cf_bank_req", 64'(breq), 64'b0010);
            check("cf_bank_addr", 64'(baddr[1]), 64'(i % 4));
            if (i > 0) begin
                check("cf_vld", 64'(vld), 64'(4'b0001 << ((i - 1) % 4)));
                check("cf_rdata", 64'(rdata[(i - 1) % 4]), 64'(32'hA001_0000 | 32'((i - 1) % 4)));
            end
            cyc();
        end
        req = '0;
        #1;
        check("cf_last_vld", 64'(vld), 64'b0001);
        check("cf_last_rdata", 64'(rdata[0]), 64'hA001_0000);
        cyc();
        check("idle_vld", 64'(vld), 64'h0);
        check("idle_rdata0", 64'(rdata[0]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_tcdm_arbiter.md
TILE_TCDM_ARBITER -- requirements
Module: tile_tcdm_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 4: number of requesting ports.
REQ-002 SHALL have parameter BankingFactor, default 4: number of SRAM banks (power of two, >=2).
REQ-003 SHALL have parameter AddrWidth, default 32, and DataWidth, default 32; BeWidth = DataWidth/8; ByteOffset = log2(BeWidth).
REQ-004 SHALL have parameter BankWords, default 1024: words per bank; BankAddrWidth = log2(BankWords).
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset); one clock; reset synchronous, active-high.
REQ-006 SHALL have port req_i (in, NumPorts, request valid per port).
REQ-007 SHALL have ports addr_i (in, NumPorts x AddrWidth, byte address), we_i (in, NumPorts, write), wdata_i (in, NumPorts x DataWidth), be_i (in, NumPorts x BeWidth).
REQ-008 SHALL have ports gnt_o (out, NumPorts, request accepted), vld_o (out, NumPorts, response valid), rdata_o (out, NumPorts x DataWidth), err_o (out, NumPorts, response is address error).
REQ-009 SHALL have bank ports bank_req_o (out, BankingFactor), bank_we_o (out, BankingFactor), bank_addr_o (out, BankingFactor x BankAddrWidth), bank_wdata_o (out, BankingFactor x DataWidth), bank_be_o (out, BankingFactor x BeWidth), bank_rdata_i (in, BankingFactor x DataWidth, valid exactly one cycle after bank_req_o).

Function
REQ-010 SHALL decode bank = addr_i[ByteOffset +: log2(BankingFactor)] and row = addr_i[ByteOffset+log2(BankingFactor) +: BankAddrWidth] (word interleaving).
REQ-011 SHALL flag a request out-of-range when addr_i >= BankingFactor*BankWords*BeWidth; such a request SHALL be granted in the same cycle, touch no bank, and return vld_o=1, err_o=1, rdata_o=0 the next cycle.
REQ-012 SHALL arbitrate each bank independently with round-robin: search starts at pointer rr_q[bank], first requesting in-range port targeting that bank wins.
REQ-013 SHALL update rr_q[bank] to (winner+1) mod NumPorts only in cycles where that bank grants; unchanged otherwise.
REQ-014 SHALL assert gnt_o[p] combinationally in the cycle of the request; at most one grant per bank per cycle; one request per port per cycle.
REQ-015 SHALL drive bank_req_o/we/addr/wdata/be of a bank from its winner in the same cycle; all bank outputs 0 when idle.
REQ-016 SHALL assert vld_o[p] exactly one cycle after gnt_o[p], for reads and writes, err_o=0; rdata_o = bank_rdata_i of the registered bank for reads, 0 for writes.
REQ-017 SHALL support back-to-back requests from one port: grant every cycle, one vld_o per grant, in order, fixed latency 1.
REQ-018 SHALL hold vld_o, err_o, rdata_o at 0 in cycles with no response due.
REQ-019 SHALL keep per-port response state (valid, bank index, we, err) in registers; no other buffering.
REQ-020 Non-granted requests SHALL see gnt_o=0; requester holds req and payload until granted (no loss, no retry state inside).

Reset
REQ-021 While rst_i=1 at a clock edge: rr_q all 0, response registers cleared; gnt_o and bank_req_o forced 0 during rst_i.
REQ-022 A grant in the cycle before reset assertion SHALL produce no vld_o in the reset cycle or after.
REQ-023 First cycle after rst_i deasserts SHALL accept requests normally.

Verification
REQ-024 Single read: port 0 reads 0x0000_0008 (BankingFactor=4) -> bank_req_o=0b0100, bank_addr_o[2]=0, gnt_o[0]=1; next cycle vld_o[0]=1, rdata_o[0]=bank_rdata_i[2].
REQ-025 Conflict: ports 0..3 all read bank 1 every cycle from reset -> grants rotate 0,1,2,3,0; each port exactly one vld_o per 4 cycles.
REQ-026 No conflict: ports 0..3 address 0x0,0x4,0x8,0xC same cycle -> all four gnt_o=1, four bank_req_o=1, four vld_o next cycle.
REQ-027 Out of range: port 2 writes 0x0000_4000 (default params) -> gnt_o[2]=1, bank_req_o=0; next cycle vld_o[2]=1, err_o[2]=1, rdata_o[2]=0.
REQ-028 Write then read: port 1 writes 0xDEADBEEF be=0xF to 0x14, then reads 0x14 -> bank 1 row 1 written; write vld rdata 0; read vld rdata 0xDEADBEEF (bank model).
REQ-029 Reset mid-operation: grant at cycle t, rst_i=1 at t+1 -> vld_o stays 0; after release rr_q restarts at port 0.
